// File: rtl/memory_arbiter_if.sv
// rtl/memory_arbiter_if.sv - core request ports and single-port RAM port of the arbiter
interface memory_arbiter_if;
  logic        c0_req;
  logic        c0_we;
  logic [15:0] c0_addr;
  logic [15:0] c0_wdata;
  logic [15:0] c0_rdata;
  logic        c0_done;
  logic        c1_req;
  logic        c1_we;
  logic [15:0] c1_addr;
  logic [15:0] c1_wdata;
  logic [15:0] c1_rdata;
  logic        c1_done;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy;

  modport slave (
    input  c0_req, c0_we, c0_addr, c0_wdata,
    input  c1_req, c1_we, c1_addr, c1_wdata,
    input  mem_rdata,
    output c0_rdata, c0_done, c1_rdata, c1_done,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output c0_req, c0_we, c0_addr, c0_wdata,
    output c1_req, c1_we, c1_addr, c1_wdata,
    output mem_rdata,
    input  c0_rdata, c0_done, c1_rdata, c1_done,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - two-core round-robin arbiter for a single-port RAM
// Fixed four-cycle transaction: IDLE -> ACCESS -> CAPTURE -> DONE.
module memory_arbiter (
  input  logic            clk,
  input  logic            rst,
  memory_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_grant_q, last_grant_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] c0_rdata_q, c0_rdata_d;
  logic [15:0] c1_rdata_q, c1_rdata_d;
  logic        winner;

  // Core 1 wins only when alone or when core 0 held the previous grant.
  assign winner = bus.c1_req && (!bus.c0_req || !last_grant_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= 16'h0000;
      wdata_q      <= 16'h0000;
      c0_rdata_q   <= 16'h0000;
      c1_rdata_q   <= 16'h0000;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      c0_rdata_q   <= c0_rdata_d;
      c1_rdata_q   <= c1_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    c0_rdata_d   = c0_rdata_q;
    c1_rdata_d   = c1_rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.c0_req || bus.c1_req) begin
          state_d      = ACCESS;
          owner_d      = winner;
          last_grant_d = winner;
          we_d         = winner ? bus.c1_we    : bus.c0_we;
          addr_d       = winner ? bus.c1_addr  : bus.c0_addr;
          wdata_d      = winner ? bus.c1_wdata : bus.c0_wdata;
        end
      end
      ACCESS: state_d = CAPTURE;
      CAPTURE: begin
        state_d = DONE;
        if (!we_q) begin
          if (owner_q) c1_rdata_d = bus.mem_rdata;
          else         c0_rdata_d = bus.mem_rdata;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_en    = (state_q == ACCESS);
  assign bus.mem_we    = (state_q == ACCESS) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.c0_rdata  = c0_rdata_q;
  assign bus.c1_rdata  = c1_rdata_q;
  assign bus.c0_done   = (state_q == DONE) && !owner_q;
  assign bus.c1_done   = (state_q == DONE) && owner_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - scoreboard bench for memory_arbiter with a RAM model
module tb_memory_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  memory_arbiter_if bus();
  memory_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  exp_t        head;
  logic [15:0] ram [0:65535];
  logic [15:0] mdl [0:65535];
  logic [15:0] exp_rd [2];
  int          tests = 0;
  int          fails = 0;
  int          acc_cnt [2];
  int          done_cnt [2];
  int          acc_cyc [2];
  int          cyc = 0;
  int          own;
  int          exp_win;
  int          last_win = 1;
  bit          mon_on = 1'b0;
  bit          prev_idle = 1'b0;
  bit          prev_r0 = 1'b0;
  bit          prev_r1 = 1'b0;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got event expected none", name);
  endtask

  task automatic drive(input int c, input logic req, input logic we,
                       input logic [15:0] addr, input logic [15:0] wdata);
    if (c == 0) begin
      bus.c0_req = req; bus.c0_we = we; bus.c0_addr = addr; bus.c0_wdata = wdata;
    end else begin
      bus.c1_req = req; bus.c1_we = we; bus.c1_addr = addr; bus.c1_wdata = wdata;
    end
  endtask

  task automatic set_req(input int c, input logic req);
    if (c == 0) bus.c0_req = req;
    else        bus.c1_req = req;
  endtask

  // Core 0 uses even addresses and core 1 odd ones, so each core's memory view is private.
  task automatic do_op(input int c, input logic we, input logic [15:0] addr,
                       input logic [15:0] wdata, input bit drop);
    exp_t e;
    int   a0, d0, n;
    e.we = we; e.addr = addr; e.wdata = wdata;
    if (we) begin
      mdl[addr] = wdata;
      e.rdata   = exp_rd[c];
    end else begin
      e.rdata   = mdl[addr];
      exp_rd[c] = mdl[addr];
    end
    if (c == 0) q0.push_back(e);
    else        q1.push_back(e);
    a0 = acc_cnt[c];
    d0 = done_cnt[c];
    drive(c, 1'b1, we, addr, wdata);
    if (drop) begin
      n = 0;
      while (acc_cnt[c] == a0 && n < 50) begin @(negedge clk); #1; n++; end
      if (acc_cnt[c] == a0) fail_now("access_timeout");
      set_req(c, 1'b0);
    end
    n = 0;
    while (done_cnt[c] == d0 && n < 50) begin @(posedge clk); #1; n++; end
    if (done_cnt[c] == d0) fail_now("done_timeout");
    set_req(c, 1'b0);
  endtask

  task automatic rand_core(input int c, input int num);
    logic [31:0] r;
    logic [15:0] a;
    int          sel, g;
    for (int i = 0; i < num; i++) begin
      r   = $urandom;
      a   = r[15:0];
      sel = $urandom_range(0, 5);
      if (sel < 3)  a = {12'h000, a[3:0]};
      if (sel == 3) a = (c == 0) ? 16'h0000 : 16'hFFFF;
      a[0] = c[0];
      r = $urandom;
      do_op(c, r[0], a, r[31:16], ($urandom_range(0, 3) == 0));
      g = $urandom_range(0, 2);
      repeat (g) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = init_val(i[15:0]);
    ram[16'hFFFF] = 16'h00AB;
    bus.mem_rdata = 16'h0000;
    forever begin
      @(posedge clk);
      if (bus.mem_en) begin
        if (bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
        else            bus.mem_rdata <= ram[bus.mem_addr];
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        last_win  = 1;
        prev_idle = 1'b0;
      end else if (mon_on) begin
        cyc++;
        if (prev_idle) begin
          chk("grant_on_req", {15'd0, bus.mem_en}, {15'd0, prev_r0 | prev_r1});
          if (bus.mem_en) begin
            own     = bus.mem_addr[0] ? 1 : 0;
            exp_win = (prev_r0 && prev_r1) ? 1 - last_win : (prev_r0 ? 0 : 1);
            chk("arb_winner", own[15:0], exp_win[15:0]);
            last_win = own;
            if ((own == 0 && q0.size() == 0) || (own == 1 && q1.size() == 0)) begin
              fail_now("access_without_request");
            end else begin
              head = (own == 0) ? q0[0] : q1[0];
              chk("acc_we", {15'd0, bus.mem_we}, {15'd0, head.we});
              chk("acc_addr", bus.mem_addr, head.addr);
              chk("acc_wdata", bus.mem_wdata, head.wdata);
            end
            acc_cyc[own] = cyc;
            acc_cnt[own]++;
          end
        end else if (bus.mem_en) begin
          fail_now("mem_en_while_busy");
        end
        if (bus.mem_we && !bus.mem_en) fail_now("mem_we_without_en");
        if (bus.c0_done && bus.c1_done) fail_now("both_done");
        for (int c = 0; c < 2; c++) begin
          if ((c == 0) ? bus.c0_done : bus.c1_done) begin
            chk("done_latency", 16'(cyc - acc_cyc[c]), 16'd2);
            chk("busy_in_done", {15'd0, bus.busy}, 16'd1);
            if ((c == 0 && q0.size() == 0) || (c == 1 && q1.size() == 0)) begin
              fail_now("done_without_request");
            end else begin
              head = (c == 0) ? q0.pop_front() : q1.pop_front();
              chk((c == 0) ? "c0_rdata" : "c1_rdata",
                  (c == 0) ? bus.c0_rdata : bus.c1_rdata, head.rdata);
            end
            done_cnt[c]++;
          end
        end
        prev_idle = !bus.busy;
        prev_r0   = bus.c0_req;
        prev_r1   = bus.c1_req;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  d_at;
    bit  seen;
    logic [15:0] rd_at;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    exp_rd[0] = 16'h0000;
    exp_rd[1] = 16'h0000;
    for (int i = 0; i < 65536; i++) mdl[i] = init_val(i[15:0]);
    mdl[16'hFFFF] = 16'h00AB;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_c0_rdata", bus.c0_rdata, 16'h0000);
    chk("rst_c1_rdata", bus.c1_rdata, 16'h0000);
    chk("rst_done", {14'd0, bus.c0_done, bus.c1_done}, 16'h0000);
    chk("rst_mem_en_we", {14'd0, bus.mem_en, bus.mem_we}, 16'h0000);
    chk("rst_mem_addr", bus.mem_addr, 16'h0000);
    chk("rst_mem_wdata", bus.mem_wdata, 16'h0000);
    chk("rst_busy", {15'd0, bus.busy}, 16'h0000);

    rst    = 1'b0;
    mon_on = 1'b1;
    fork
      do_op(0, 1'b1, 16'd100, 16'd127, 1'b0);
      do_op(1, 1'b0, 16'hFFFF, 16'h0000, 1'b0);
    join
    do_op(0, 1'b1, 16'h0000, 16'hBEEF, 1'b0);
    do_op(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    do_op(1, 1'b1, 16'hFFFF, 16'h1234, 1'b0);
    do_op(1, 1'b0, 16'hFFFF, 16'h0000, 1'b0);
    do_op(0, 1'b0, 16'd200, 16'h0000, 1'b1);
    repeat (4) begin @(posedge clk); #1; end
    fork
      for (int i = 0; i < 4; i++) do_op(0, 1'b0, 16'(2 * i), 16'h0000, 1'b0);
      for (int j = 0; j < 4; j++) do_op(1, 1'b1, 16'(2 * j + 1), 16'(j + 16'h0C00), 1'b0);
    join
    fork
      rand_core(0, 60);
      rand_core(1, 60);
    join
    repeat (3) begin @(posedge clk); #1; end
    chk("q0_drained", 16'(q0.size()), 16'd0);
    chk("q1_drained", 16'(q1.size()), 16'd0);
    mon_on = 1'b0;

    drive(1, 1'b1, 1'b0, 16'h0003, 16'h0000);
    @(posedge clk); #1;
    chk("midrst_access", {15'd0, bus.mem_en}, 16'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", {15'd0, bus.busy}, 16'd0);
    chk("midrst_rdata", bus.c1_rdata, 16'h0000);
    chk("midrst_mem_en", {15'd0, bus.mem_en}, 16'd0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.c0_done || bus.c1_done || bus.mem_en) seen = 1'b1;
    end
    chk("midrst_no_done", {15'd0, seen}, 16'd0);
    rst   = 1'b0;
    d_at  = 0;
    seen  = 1'b0;
    rd_at = 16'h0000;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (bus.c1_done && d_at == 0) begin d_at = k; rd_at = bus.c1_rdata; end
      if (bus.c0_done) seen = 1'b1;
    end
    chk("rearb_latency", d_at[15:0], 16'd3);
    chk("rearb_rdata", rd_at, mdl[16'h0003]);
    chk("rearb_c0_quiet", {15'd0, seen}, 16'd0);
    set_req(1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
